// File: rtl/qpp_llr_interleaver.sv
// QPP interleaver/deinterleaver for FPTD extrinsic LLR frames; permutation addresses come from an
// add-only QPP recursion. Define FPTD_ILV_DOUBLE_BUFFER_EN for ping-pong buffering (load overlaps drain).
module qpp_llr_interleaver #(
   parameter int FL = 104,
   parameter int M  = 5,
   parameter int F1 = 7,
   parameter int F2 = 26
) (
   input  logic         Clock,
   input  logic         nReset,
   input  logic         Mode,
   input  logic         In_Valid,
   output logic         In_Ready,
   input  logic [M-1:0] In_Data,
   output logic         Out_Valid,
   input  logic         Out_Ready,
   output logic [M-1:0] Out_Data,
   output logic         Out_Last,
   output logic         Busy
);
   localparam int W  = $clog2(FL) + 1;
   localparam int AW = $clog2(FL);
   localparam logic [W-1:0] FL_W   = W'(FL);
   localparam logic [W-1:0] LAST_W = W'(FL - 1);
   localparam logic [W-1:0] D_W    = W'((2 * F2) % FL);
   localparam logic [W-1:0] G0_W   = W'((F1 + F2) % FL);
   localparam logic [W-1:0] ONE_W  = W'(1);
`ifdef FPTD_ILV_DOUBLE_BUFFER_EN
   localparam logic DBUF = 1'b1;
`else
   localparam logic DBUF = 1'b0;
`endif

   generate
      if (FL < 8 || F1 <= 0 || F1 >= FL || F2 < 0 || F2 >= FL) begin : g_bad_params
         $error("qpp_llr_interleaver: illegal FL/F1/F2 parameter combination");
      end
   endgenerate

   typedef enum logic {LOAD = 1'b0, DRAIN = 1'b1} state_t;

   // Operands are always < FL, so a single conditional subtract completes the modulo.
   function automatic logic [W-1:0] mod_add(input logic [W-1:0] a, input logic [W-1:0] b);
      logic [W-1:0] s;
      s = a + b;
      if (s >= FL_W) begin
         mod_add = s - FL_W;
      end else begin
         mod_add = s;
      end
   endfunction

   logic [M-1:0] mem_r [0:1][0:FL-1];

   state_t       state_r, state_s;
   logic         in_ready_r, in_ready_s;
   logic [M-1:0] out_data_r, out_data_s;
   logic         out_last_r, out_last_s;
   logic         busy_r, busy_s;
   logic         wr_sel_r, wr_sel_s, rd_sel_r, rd_sel_s;
   logic [1:0]   full_r, full_s, mode_r, mode_s;
   logic [W-1:0] wr_cnt_r, wr_cnt_s, wr_pi_r, wr_pi_s, wr_g_r, wr_g_s;
   logic [W-1:0] rd_cnt_r, rd_cnt_s, rd_pi_r, rd_pi_s, rd_g_r, rd_g_s;

   logic          wr_hs_s, wr_mode_s, wr_last_s, rd_hs_s, rd_last_s, rd_buf_s;
   logic [AW-1:0] wr_addr_s, rd_addr_s;
   logic [W-1:0]  rd_nidx_s, rd_npi_s;
   logic [1:0]    full_set_s, full_clr_s;

   // Mode is taken live on a frame's first symbol, from the per-buffer latch afterwards.
   assign wr_hs_s    = In_Valid & in_ready_r;
   assign wr_mode_s  = (wr_cnt_r == {W{1'b0}}) ? Mode : mode_r[wr_sel_r];
   assign wr_addr_s  = wr_mode_s ? wr_pi_r[AW-1:0] : wr_cnt_r[AW-1:0];
   assign wr_last_s  = wr_hs_s & (wr_cnt_r == LAST_W);
   assign rd_hs_s    = (state_r == DRAIN) & Out_Ready;
   assign rd_last_s  = rd_hs_s & (rd_cnt_r == LAST_W);
   assign rd_nidx_s  = rd_cnt_r + ONE_W;
   assign rd_npi_s   = mod_add(rd_pi_r, rd_g_r);
   assign rd_addr_s  = mode_r[rd_sel_r] ? rd_nidx_s[AW-1:0] : rd_npi_s[AW-1:0];
   assign rd_buf_s   = (state_r == DRAIN) ? (rd_sel_r ^ DBUF) : rd_sel_r;
   assign full_set_s = wr_last_s ? (2'b01 << wr_sel_r) : 2'b00;
   assign full_clr_s = rd_last_s ? (2'b01 << rd_sel_r) : 2'b00;
   assign full_s     = (full_r | full_set_s) & ~full_clr_s;
   assign in_ready_s = ~full_s[wr_sel_s];
   assign busy_s     = (full_s != 2'b00) || (wr_cnt_s != {W{1'b0}});

   // Write-side sequencing: symbol count and QPP recursion for deinterleave write addresses.
   always_comb begin
      wr_sel_s = wr_sel_r;
      wr_cnt_s = wr_cnt_r;
      wr_pi_s  = wr_pi_r;
      wr_g_s   = wr_g_r;
      mode_s   = mode_r;
      if (wr_last_s) begin
         mode_s[wr_sel_r] = wr_mode_s;
         wr_sel_s         = wr_sel_r ^ DBUF;
         wr_cnt_s         = {W{1'b0}};
         wr_pi_s          = {W{1'b0}};
         wr_g_s           = G0_W;
      end else if (wr_hs_s) begin
         mode_s[wr_sel_r] = wr_mode_s;
         wr_cnt_s         = wr_cnt_r + ONE_W;
         wr_pi_s          = mod_add(wr_pi_r, wr_g_r);
         wr_g_s           = mod_add(wr_g_r, D_W);
      end else begin
         wr_sel_s = wr_sel_r;
      end
   end

   // Read-side FSM: prefetch symbol 0 once a buffer fills, then one symbol per output handshake.
   always_comb begin
      state_s    = state_r;
      out_data_s = out_data_r;
      out_last_s = out_last_r;
      rd_sel_s   = rd_sel_r;
      rd_cnt_s   = rd_cnt_r;
      rd_pi_s    = rd_pi_r;
      rd_g_s     = rd_g_r;
      if ((state_r == LOAD) || rd_last_s) begin
         rd_sel_s   = rd_buf_s;
         rd_cnt_s   = {W{1'b0}};
         rd_pi_s    = {W{1'b0}};
         rd_g_s     = G0_W;
         out_last_s = 1'b0;
         if (full_s[rd_buf_s]) begin
            state_s    = DRAIN;
            out_data_s = mem_r[rd_buf_s][{AW{1'b0}}];
         end else begin
            state_s = LOAD;
         end
      end else if (rd_hs_s) begin
         state_s    = DRAIN;
         rd_cnt_s   = rd_nidx_s;
         rd_pi_s    = rd_npi_s;
         rd_g_s     = mod_add(rd_g_r, D_W);
         out_data_s = mem_r[rd_sel_r][rd_addr_s];
         out_last_s = (rd_nidx_s == LAST_W);
      end else begin
         state_s = DRAIN;
      end
   end

   // Control and output registers.
   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         state_r    <= LOAD;
         in_ready_r <= 1'b1;
         out_data_r <= {M{1'b0}};
         out_last_r <= 1'b0;
         busy_r     <= 1'b0;
         wr_sel_r   <= 1'b0;
         rd_sel_r   <= 1'b0;
         full_r     <= 2'b00;
         mode_r     <= 2'b00;
         wr_cnt_r   <= {W{1'b0}};
         wr_pi_r    <= {W{1'b0}};
         wr_g_r     <= G0_W;
         rd_cnt_r   <= {W{1'b0}};
         rd_pi_r    <= {W{1'b0}};
         rd_g_r     <= G0_W;
      end else begin
         state_r    <= state_s;
         in_ready_r <= in_ready_s;
         out_data_r <= out_data_s;
         out_last_r <= out_last_s;
         busy_r     <= busy_s;
         wr_sel_r   <= wr_sel_s;
         rd_sel_r   <= rd_sel_s;
         full_r     <= full_s;
         mode_r     <= mode_s;
         wr_cnt_r   <= wr_cnt_s;
         wr_pi_r    <= wr_pi_s;
         wr_g_r     <= wr_g_s;
         rd_cnt_r   <= rd_cnt_s;
         rd_pi_r    <= rd_pi_s;
         rd_g_r     <= rd_g_s;
      end
   end

   // Frame buffer storage, deliberately not reset.
   always_ff @(posedge Clock) begin
      if (wr_hs_s) begin
         mem_r[wr_sel_r][wr_addr_s] <= In_Data;
      end
   end

   assign In_Ready  = in_ready_r;
   assign Out_Valid = (state_r == DRAIN);
   assign Out_Data  = out_data_r;
   assign Out_Last  = out_last_r;
   assign Busy      = busy_r;

endmodule

// File: tb/tb_qpp_llr_interleaver.sv
// Self-checking bench for qpp_llr_interleaver; expected orders come from the closed-form
// QPP polynomial pi(i) = (F1*i + F2*i^2) mod FL.
module tb_qpp_llr_interleaver;
   localparam int FLA = 104;
   localparam int FLB = 40;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [1:0]      mode, in_valid, out_ready;
   logic [1:0][7:0] din;
   logic [1:0]      in_ready, out_valid, out_last, busy;
   logic [7:0]      dout_a, dout_b;
   int              checks = 0;
   int              fails  = 0;

   always #5 clk = ~clk;

   qpp_llr_interleaver #(.FL(FLA), .M(8), .F1(7), .F2(26)) dut_a (
      .Clock(clk), .nReset(rst_n), .Mode(mode[0]), .In_Valid(in_valid[0]), .In_Ready(in_ready[0]),
      .In_Data(din[0]), .Out_Valid(out_valid[0]), .Out_Ready(out_ready[0]), .Out_Data(dout_a),
      .Out_Last(out_last[0]), .Busy(busy[0]));

   qpp_llr_interleaver #(.FL(FLB), .M(8), .F1(3), .F2(10)) dut_b (
      .Clock(clk), .nReset(rst_n), .Mode(mode[1]), .In_Valid(in_valid[1]), .In_Ready(in_ready[1]),
      .In_Data(din[1]), .Out_Valid(out_valid[1]), .Out_Ready(out_ready[1]), .Out_Data(dout_b),
      .Out_Last(out_last[1]), .Busy(busy[1]));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
      end
   endtask

   function automatic logic [7:0] dsel(input int sel);
      return (sel != 0) ? dout_b : dout_a;
   endfunction

   function automatic int pi_of(input int i, input int fl, input int f1, input int f2);
      longint v;
      v = longint'(f1) * i + longint'(f2) * i * i;
      return int'(v % fl);
   endfunction

   task automatic model(input int fl, input int f1, input int f2, input logic md,
                        input logic [7:0] d[$], output logic [7:0] e[$]);
      e = d;
      for (int i = 0; i < fl; i++) begin
         if (md) e[pi_of(i, fl, f1, f2)] = d[i];
         else    e[i] = d[pi_of(i, fl, f1, f2)];
      end
   endtask

   task automatic send(input int sel, input int n, input logic md, input bit gaps, input bit tog,
                       input logic [7:0] d[$]);
      for (int i = 0; i < n; ) begin
         @(negedge clk);
         if (gaps && $urandom_range(0, 2) == 0) begin
            in_valid[sel] = 1'b0;
         end else begin
            chk("in_ready_load", in_ready[sel], 1);
            chk("out_valid_load", out_valid[sel], 0);
            in_valid[sel] = 1'b1;
            din[sel]      = d[i];
            mode[sel]     = (tog && i > 0) ? ~md : md;
            i++;
         end
      end
      @(negedge clk);
      in_valid[sel] = 1'b0;
   endtask

   task automatic recv(input int sel, input int fl, input logic [7:0] ref_q[$], input bit rnd,
                       output logic [7:0] got[$]);
      int k   = 0;
      int cyc = 0;
      got = {};
      while (k < fl && cyc < 4 * fl + 20) begin
         if (out_valid[sel]) begin
            chk("out_data", dsel(sel), ref_q[k]);
            chk("out_last", out_last[sel], (k == fl - 1));
         end
         chk("in_ready_drain", in_ready[sel], 0);
         out_ready[sel] = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         if (out_valid[sel] && out_ready[sel]) begin
            got.push_back(dsel(sel));
            k++;
         end
         cyc++;
         @(negedge clk);
      end
      out_ready[sel] = 1'b0;
      chk("drain_count", k, fl);
      chk("out_valid_end", out_valid[sel], 0);
      chk("in_ready_end", in_ready[sel], 1);
      chk("busy_end", busy[sel], 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [7:0] d[$], e[$], got[$], got1[$], orig[$];
      rst_n = 1'b0; mode = 2'b00; in_valid = 2'b00; out_ready = 2'b00; din = '0;
      repeat (3) @(negedge clk);
      chk("rst_in_ready", in_ready[0], 1);
      chk("rst_out_valid", out_valid[0], 0);
      chk("rst_out_data", dout_a, 0);
      chk("rst_out_last", out_last[0], 0);
      chk("rst_busy", busy[0], 0);
      chk("rst_in_ready_b", in_ready[1], 1);
      rst_n = 1'b1;

      // Interleave of 0..103 with free-running output.
      d = {};
      for (int i = 0; i < FLA; i++) d.push_back(8'(i));
      model(FLA, 7, 26, 1'b0, d, e);
      send(0, FLA, 1'b0, 1'b0, 1'b0, d);
      chk("latency_valid", out_valid[0], 1);
      chk("busy_drain", busy[0], 1);
      recv(0, FLA, e, 1'b0, got);
      chk("il_out1", got[1], 33);
      chk("il_out3", got[3], 47);
      chk("il_out103", got[103], 19);

      // Deinterleave of 0..103.
      model(FLA, 7, 26, 1'b1, d, e);
      send(0, FLA, 1'b1, 1'b0, 1'b0, d);
      chk("latency_valid_di", out_valid[0], 1);
      recv(0, FLA, e, 1'b0, got);
      chk("di_out1", got[1], 41);
      chk("di_out33", got[33], 1);
      chk("di_out13", got[13], 13);
      chk("di_out103", got[103], 11);

      // Random data, random output backpressure.
      d = {};
      for (int i = 0; i < FLA; i++) d.push_back(8'($urandom));
      model(FLA, 7, 26, 1'b0, d, e);
      send(0, FLA, 1'b0, 1'b0, 1'b0, d);
      recv(0, FLA, e, 1'b1, got);

      // Random input gaps, Mode flipped after the first symbol.
      d = {};
      for (int i = 0; i < FLA; i++) d.push_back(8'($urandom));
      model(FLA, 7, 26, 1'b1, d, e);
      send(0, FLA, 1'b1, 1'b1, 1'b1, d);
      chk("latency_valid_gaps", out_valid[0], 1);
      recv(0, FLA, e, 1'b0, got);

      // Reset mid-frame after 50 symbols, then a fresh frame.
      d = {};
      for (int i = 0; i < FLA; i++) d.push_back(8'($urandom));
      send(0, 50, 1'b0, 1'b0, 1'b0, d);
      chk("busy_partial", busy[0], 1);
      rst_n = 1'b0;
      #1;
      chk("rst_mid_valid", out_valid[0], 0);
      chk("rst_mid_ready", in_ready[0], 1);
      chk("rst_mid_busy", busy[0], 0);
      @(negedge clk);
      rst_n = 1'b1;
      d = {};
      for (int i = 0; i < FLA; i++) d.push_back(8'($urandom));
      model(FLA, 7, 26, 1'b0, d, e);
      send(0, FLA, 1'b0, 1'b0, 1'b0, d);
      chk("latency_valid_post_rst", out_valid[0], 1);
      recv(0, FLA, e, 1'b0, got);

      // FL=40: interleave then deinterleave restores the original order.
      orig = {};
      for (int i = 0; i < FLB; i++) orig.push_back(8'(i));
      model(FLB, 3, 10, 1'b0, orig, e);
      send(1, FLB, 1'b0, 1'b0, 1'b0, orig);
      chk("latency_valid_b", out_valid[1], 1);
      recv(1, FLB, e, 1'b0, got1);
      send(1, FLB, 1'b1, 1'b0, 1'b0, got1);
      recv(1, FLB, orig, 1'b1, got);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule

// File: doc/qpp_llr_interleaver.md
Name: qpp_llr_interleaver

Overview:
- Parametrised, sequential QPP interleaver/deinterleaver for extrinsic LLR frames exchanged between the upper and lower FPTD decoders.
- Replaces fixed hard-wired permutation networks. One LLR is accepted per cycle into a frame buffer, then emitted in permuted order.
- Permutation addresses are generated on the fly by QPP recursion, so any frame length and F1/F2 pair is supported.
- Mode input selects interleave (upper to lower) or deinterleave (lower to upper).

Parameters:
- FL, 104, frame length K in symbols (>=8).
- M, 5, LLR width in bits (signed).
- F1, 7, QPP linear coefficient (0 < F1 < FL).
- F2, 26, QPP quadratic coefficient (0 <= F2 < FL).

Ports:
- Clock  input  1  system clock, rising edge.
- nReset  input  1  asynchronous, active-low reset.
- Mode  input  1  0 = interleave, 1 = deinterleave; sampled on the first input handshake of a frame.
- In_Valid  input  1  In_Data valid.
- In_Ready  output  1  block can accept a symbol.
- In_Data  input  M  signed LLR, natural order.
- Out_Valid  output  1  Out_Data valid.
- Out_Ready  input  1  downstream accepts.
- Out_Data  output  M  signed LLR, permuted order.
- Out_Last  output  1  high with the final (index FL-1) output symbol.
- Busy  output  1  frame in progress (not in LOAD with count 0).

Behaviour:
- Reset values: In_Ready=1, Out_Valid=0, Out_Data=0, Out_Last=0, Busy=0. State=LOAD, counters=0, pi=0, g=(F1+F2) mod FL.
- Buffer: FL x M register array. Contents are not reset.
- QPP recursion, all operands < FL:
  - pi(0)=0.
  - pi(i+1)=(pi(i)+g(i)) mod FL.
  - g(i+1)=(g(i)+D) mod FL, where localparam D=(2*F2) mod FL.
  - Each mod is a single compare-and-subtract. No multipliers.
  - Width is clog2(FL)+1 bits.
- Interleave mode: write addr = i (sequential); read addr = pi(i). Result: out[i]=in[pi(i)].
- Deinterleave mode: write addr = pi(i); read addr = i. Result: out[pi(i)]=in[i].
- The recursion runs during whichever phase uses pi, and is reset to pi=0, g=(F1+F2) mod FL at each phase start.
- State LOAD:
  - In_Ready=1.
  - Handshake is In_Valid&&In_Ready. Each handshake writes one symbol and increments the write count.
  - Gaps in In_Valid stall without corruption.
  - Mode is latched on the handshake where count==0.
  - On the handshake with count==FL-1, go to DRAIN next cycle.
- State DRAIN:
  - In_Ready=0.
  - Out_Valid is high from the cycle after the last input handshake (latency 1).
  - Out_Data is registered and holds stable while Out_Valid&&!Out_Ready.
  - Each Out_Valid&&Out_Ready handshake advances the read index. The next symbol appears the following cycle, giving 1 symbol/cycle with Out_Ready held high.
  - Out_Last=1 with the index FL-1 symbol.
  - On that handshake go to LOAD, Out_Valid=0, In_Ready=1 next cycle.
- Throughput: one frame per 2*FL cycles, with no backpressure and no input gaps.
- Mode changes mid-frame are ignored until the next frame.
- Reset asserted mid-frame returns to reset values immediately. The partial frame is discarded. The first symbol after reset release is index 0.
- Elaboration error if FL<8, F1==0, F1>=FL or F2>=FL. QPP validity of the (F1, F2) pair is the integrator's responsibility.

Optional Feature:
- Macro FPTD_ILV_DOUBLE_BUFFER_EN.
- Defined:
  - Two FL-deep buffers in ping-pong. LOAD of frame n+1 overlaps DRAIN of frame n.
  - In_Ready deasserts only when both buffers hold undrained frames.
  - Mode is latched per buffer.
  - Sustained throughput is 1 symbol/cycle.
  - The first frame's latency is unchanged (1 cycle after its last input).
- Undefined: single buffer with the LOAD/DRAIN alternation above. In_Ready=0 throughout DRAIN.

Test Plan:
- FL=104, M=8, F1=7, F2=26, Mode=0, In_Data=i for i=0..103, Out_Ready=1 -> output sequence 0,33,14,47,28,61,…,90,19. Out_Last only on 19. Out_Valid rises 1 cycle after input 103.
- Same parameters, Mode=1, In_Data=i -> out[0]=0, out[1]=41, out[33]=1, out[13]=13, out[103]=11. The sequence is the exact inverse permutation.
- Out_Ready toggled randomly (50%) during DRAIN -> Out_Data stable whenever stalled. Same 104-value sequence. No In_Ready during DRAIN (single-buffer build).
- In_Valid with random gaps during LOAD; Mode toggled after the first symbol -> output identical to the gap-free case using the first-sampled Mode.
- nReset pulsed after 50 inputs, then a full fresh frame -> Out_Valid=0 and In_Ready=1 during reset. The next frame's output matches the reference permutation with no stale data.
- FL=40, F1=3, F2=10, back-to-back interleave then deinterleave of the same data -> the second output equals the original 0..39.
